// File: rtl/mem_resp_model_pkg.sv
// Shared types and widths for the memory-side responder model.
package mem_resp_model_pkg;

    localparam int DATA_W = 256;
    localparam int ADDR_W = 28;
    localparam int CNT_W  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mem_resp_array.sv
// Direct-mapped tag/valid/data storage with one access port.
// Only the valid bits are reset; data and tags are plain storage.
module mem_resp_array
    import mem_resp_model_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int TAG_W      = 21
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] idx_i,
    input  logic [TAG_W-1:0]      tag_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic                  hit_o,
    output logic [DATA_W-1:0]     rdata_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [DEPTH-1:0]  vld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else if (we_i) begin
            vld_q[idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            data_q[idx_i] <= wdata_i;
            tag_q[idx_i]  <= tag_i;
        end
    end

    always_comb begin
        hit_o   = vld_q[idx_i] && (tag_q[idx_i] == tag_i);
        rdata_o = data_q[idx_i];
    end

endmodule

// File: rtl/mem_resp_model.sv
// DDR2-controller stand-in: accepts one command, waits LATENCY edges,
// performs the access into a small tagged store and pulses ready.
module mem_resp_model
    import mem_resp_model_pkg::*;
#(
    parameter int LATENCY    = 3,
    parameter int DEPTH_LOG2 = 4,
    parameter int ADDR_SHIFT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] mem_data_wr1,
    output logic [DATA_W-1:0] mem_data_rd1,
    input  logic [ADDR_W-1:0] mem_data_addr1,
    input  logic              mem_rw_data1,
    input  logic              mem_valid_data1,
    output logic              mem_ready_data1,
    output logic              rd_miss,
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count
);

    localparam int LINE_W = ADDR_W - ADDR_SHIFT;
    localparam int TAG_W  = LINE_W - DEPTH_LOG2;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > 63) begin : g_bad_latency
        $error("mem_resp_model: LATENCY must be in 1..63");
    end

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                rw_q, rw_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                miss_q, miss_d;
    logic [15:0]         wr_cnt_q, wr_cnt_d;
    logic [15:0]         rd_cnt_q, rd_cnt_d;
    logic                arr_we;
    logic                arr_hit;
    logic [DATA_W-1:0]   arr_rdata;
    logic                unused_low_addr;

    assign unused_low_addr = ^mem_data_addr1[ADDR_SHIFT-1:0];

    mem_resp_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .we_i    (arr_we),
        .idx_i   (line_q[DEPTH_LOG2-1:0]),
        .tag_i   (line_q[LINE_W-1:DEPTH_LOG2]),
        .wdata_i (wdata_q),
        .hit_o   (arr_hit),
        .rdata_o (arr_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            line_q   <= '0;
            rw_q     <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            miss_q   <= 1'b0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            line_q   <= line_d;
            rw_q     <= rw_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            miss_q   <= miss_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        line_d   = line_q;
        rw_d     = rw_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        miss_d   = 1'b0;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        arr_we   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_valid_data1) begin
                    line_d  = mem_data_addr1[ADDR_W-1:ADDR_SHIFT];
                    rw_d    = mem_rw_data1;
                    wdata_d = mem_data_wr1;
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // The access itself happens on the BUSY->RESP edge.
                    state_d = RESP;
                    if (rw_q) begin
                        arr_we   = 1'b1;
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                        rdata_d  = arr_hit ? arr_rdata : '0;
                        miss_d   = ~arr_hit;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_ready_data1 = (state_q == RESP);
    assign rd_miss         = miss_q;
    assign mem_data_rd1    = rdata_q;
    assign wr_count        = wr_cnt_q;
    assign rd_count        = rd_cnt_q;

endmodule

// File: tb/tb_mem_resp_model.sv
// Randomised and directed checks of mem_resp_model against a line-addressed
// behavioural memory model.
module tb_mem_resp_model;

    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] wdata, rdata;
    logic [27:0]  addr;
    logic         rw, valid, ready, miss;
    logic [15:0]  wrc, rdc;

    logic [255:0] rdata1;
    logic         valid1, ready1, miss1;
    logic [15:0]  wrc1, rdc1;

    int unsigned  total = 0;
    int unsigned  bad   = 0;

    // Model: line address (addr / 8) -> data; one resident line per index.
    logic [255:0] mdl_mem [int unsigned];
    int unsigned  mdl_wr, mdl_rd;
    logic [255:0] mdl_last_rd;
    bit           err_flag;

    always #5 clk = ~clk;

    mem_resp_model #(.LATENCY(LAT), .DEPTH_LOG2(4), .ADDR_SHIFT(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_data_wr1    (wdata),
        .mem_data_rd1    (rdata),
        .mem_data_addr1  (addr),
        .mem_rw_data1    (rw),
        .mem_valid_data1 (valid),
        .mem_ready_data1 (ready),
        .rd_miss         (miss),
        .wr_count        (wrc),
        .rd_count        (rdc)
    );

    mem_resp_model #(.LATENCY(1), .DEPTH_LOG2(4), .ADDR_SHIFT(3)) dut1 (
        .clk             (clk),
        .rst             (rst),
        .mem_data_wr1    ('0),
        .mem_data_rd1    (rdata1),
        .mem_data_addr1  (28'h0FF1010),
        .mem_rw_data1    (1'b0),
        .mem_valid_data1 (valid1),
        .mem_ready_data1 (ready1),
        .rd_miss         (miss1),
        .wr_count        (wrc1),
        .rd_count        (rdc1)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        mdl_mem.delete();
        mdl_wr      = 0;
        mdl_rd      = 0;
        mdl_last_rd = '0;
    endtask

    task automatic model_write(input logic [27:0] a, input logic [255:0] d);
        int unsigned line = int'(a) / 8;
        int unsigned kill[$];
        foreach (mdl_mem[k]) if ((k % 16) == (line % 16) && k != line) kill.push_back(k);
        foreach (kill[i]) mdl_mem.delete(kill[i]);
        mdl_mem[line] = d;
        mdl_wr++;
    endtask

    task automatic run_cmd(input bit w, input logic [27:0] a, input logic [255:0] d,
                           input string tag, input int idle);
        int          lat = 0;
        logic [255:0] exp_rd;
        bit           exp_miss;
        int unsigned  line = int'(a) / 8;
        @(negedge clk);
        valid = 1'b1; rw = w; addr = a; wdata = d;
        @(posedge clk);
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            if (ready) begin lat = k; break; end
        end
        check({tag, "_lat"}, 256'(lat), 256'(LAT));
        if (w) begin
            model_write(a, d);
            exp_miss = 1'b0;
        end else begin
            mdl_rd++;
            exp_miss    = !mdl_mem.exists(line);
            mdl_last_rd = exp_miss ? '0 : mdl_mem[line];
        end
        exp_rd = mdl_last_rd;
        if (lat != 0) begin
            check({tag, "_rd"}, rdata, exp_rd);
            check({tag, "_miss"}, 256'(miss), 256'(exp_miss));
            check({tag, "_wrc"}, 256'(wrc), 256'(mdl_wr[15:0]));
            check({tag, "_rdc"}, 256'(rdc), 256'(mdl_rd[15:0]));
            if (!w && rdata !== exp_rd) err_flag = 1'b1;
        end
        @(negedge clk);
        valid = 1'b0;
        @(posedge clk); #1;
        check({tag, "_rdy_off"}, 256'({ready, miss}), 256'(0));
        repeat (idle) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] dpat;
        logic [255:0] tg_data [9];
        logic [27:0]  tg_addr [9];
        int           pulses;

        rst = 1'b1; valid = 1'b0; valid1 = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
        model_reset();
        err_flag = 1'b0;
        #1;
        check("rst_ready", 256'({ready, miss, ready1}), 256'(0));
        check("rst_rd", rdata, '0);
        check("rst_cnt", 256'({wrc, rdc}), 256'(0));
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;

        dpat = 256'h8000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_00F0;
        run_cmd(1'b1, 28'h0FF1000, dpat, "wr0", 1);
        run_cmd(1'b0, 28'h0FF1000, '0, "rd0", 1);
        run_cmd(1'b0, 28'h0FF1008, '0, "rdmiss", 1);
        run_cmd(1'b1, 28'h3FF1038, rand256(), "alias_wr", 0);
        run_cmd(1'b0, 28'h0FF1038, '0, "alias_old", 0);
        run_cmd(1'b0, 28'h3FF1038, '0, "alias_new", 0);
        run_cmd(1'b1, 28'h3FF1038, rand256(), "wr_keep_rd", 0);

        // Reset two cycles into a write: nothing commits, ready never pulses.
        @(negedge clk);
        valid = 1'b1; rw = 1'b1; addr = 28'h0FF1040; wdata = rand256();
        @(posedge clk);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        valid = 1'b0;
        model_reset();
        check("busy_rst_ready", 256'(ready), 256'(0));
        check("busy_rst_cnt", 256'({wrc, rdc}), 256'(0));
        @(negedge clk); rst = 1'b0;
        pulses = 0;
        repeat (6) begin @(posedge clk); #1; if (ready) pulses++; end
        check("busy_rst_nopulse", 256'(pulses), 256'(0));
        run_cmd(1'b0, 28'h0FF1040, '0, "after_rst", 0);

        // Reset inside the ready cycle of a missing read drops ready/miss at once.
        @(negedge clk);
        valid = 1'b1; rw = 1'b0; addr = 28'h0FF1048;
        @(posedge clk);
        repeat (LAT) @(posedge clk);
        #1;
        check("resp_pre", 256'({ready, miss}), 256'(3));
        #2 rst = 1'b1;
        #1;
        check("resp_rst", 256'({ready, miss}), 256'(0));
        check("resp_rst_cnt", 256'({wrc, rdc}), 256'(0));
        valid = 1'b0;
        model_reset();
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            tg_addr[i] = (i < 8) ? 28'(28'h0FF1000 + i * 8) : 28'h3FF1040;
            tg_data[i] = rand256();
            run_cmd(1'b1, tg_addr[i], tg_data[i], "tg_wr", 2);
        end
        for (int i = 0; i < 9; i++) begin
            run_cmd(1'b0, tg_addr[i], '0, "tg_rd", 2);
            check("tg_data", rdata, tg_data[i]);
        end
        check("tg_err", 256'(err_flag), 256'(0));
        check("tg_counts", 256'({wrc, rdc}), 256'({16'd9, 16'd9}));

        for (int i = 0; i < 60; i++) begin
            logic [27:0] ra;
            ra = 28'((($urandom_range(0, 1) != 0) ? 32'h7FE2 : 32'h1FE2) * 128
                     + $urandom_range(0, 15) * 8 + $urandom_range(0, 7));
            run_cmd($urandom_range(0, 1) != 0, ra, rand256(), "rnd", $urandom_range(0, 2));
        end

        // LATENCY=1 with valid held high: ready every third cycle.
        @(negedge clk); valid1 = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            check("l1_ready", 256'({ready1, miss1}), (k % 3 == 1) ? 256'(3) : 256'(0));
        end
        check("l1_rdc", 256'(rdc1), 256'(3));
        @(negedge clk); valid1 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
